// File: rtl/commit_rename_sched.sv
// Retire-to-rename commit sequencer: FIFO-buffered commits plus mispredict rollback/recovery FSM.
// Optional COMMIT_RENAME_SCHED_STATS_EN adds commit/rollback counters.
module commit_rename_sched #(
  parameter int DEPTH          = 4,
  parameter int RECOVER_CYCLES = 2,
  parameter int NUM_ARCH_REG   = 32,
  parameter int NUM_PHYS_REG   = 64,
  localparam int AREG_W              = $clog2(NUM_ARCH_REG),
  localparam int PREG_W              = $clog2(NUM_PHYS_REG),
  localparam int COMMIT_RENAME_WIDTH = 1 + AREG_W + PREG_W
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           retire_v_i,
  output logic                           retire_ready_o,
  input  logic                           retire_w_v_i,
  input  logic [AREG_W-1:0]              retire_alloc_reg_i,
  input  logic [PREG_W-1:0]              retire_freed_reg_i,
  input  logic                           retire_mispred_i,
  output logic                           commit_v_o,
  output logic [COMMIT_RENAME_WIDTH-1:0] commit_rename_o,
  output logic                           mispredict_o,
  output logic                           rename_stall_o,
  output logic                           flush_o
`ifdef COMMIT_RENAME_SCHED_STATS_EN
  ,
  output logic [31:0]                    commit_cnt_o,
  output logic [15:0]                    rollback_cnt_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RECOVER_CYCLES + 1);

  typedef struct packed {
    logic              mispred;
    logic              w_v;
    logic [AREG_W-1:0] alloc_reg;
    logic [PREG_W-1:0] freed_reg;
  } entry_t;

  typedef enum logic [1:0] {RUN, ROLLBACK, RECOVER} state_e;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] rec_cnt_q, rec_cnt_d;

  entry_t head;
  logic   empty, full, push, pop, rollback_pop;

  assign head         = mem[rd_ptr];
  assign empty        = (count == '0);
  assign full         = count[PTR_W];
  assign push         = retire_v_i & retire_ready_o;
  assign pop          = commit_v_o;
  assign rollback_pop = pop & head.mispred;

  assign commit_rename_o = {head.w_v, head.alloc_reg, head.freed_reg};
  assign mispredict_o    = commit_v_o & head.mispred;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{mispred:   retire_mispred_i,
                       w_v:       retire_w_v_i,
                       alloc_reg: retire_alloc_reg_i,
                       freed_reg: retire_freed_reg_i};
    end
  end

  // A rollback commit empties the FIFO, and that flush beats any same-cycle push.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || rollback_pop) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= RUN;
      rec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rec_cnt_d      = rec_cnt_q;
    commit_v_o     = 1'b0;
    retire_ready_o = 1'b0;
    rename_stall_o = 1'b0;
    flush_o        = 1'b0;
    case (state_q)
      RUN: begin
        commit_v_o     = ~empty;
        retire_ready_o = ~full;
        if (~empty && head.mispred) state_d = ROLLBACK;
      end
      ROLLBACK: begin
        flush_o        = 1'b1;
        rename_stall_o = 1'b1;
        rec_cnt_d      = CNT_W'(RECOVER_CYCLES);
        state_d        = RECOVER;
      end
      RECOVER: begin
        rename_stall_o = 1'b1;
        rec_cnt_d      = rec_cnt_q - 1'b1;
        if (rec_cnt_q == CNT_W'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

`ifdef COMMIT_RENAME_SCHED_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      commit_cnt_o   <= '0;
      rollback_cnt_o <= '0;
    end else begin
      if (commit_v_o)          commit_cnt_o   <= commit_cnt_o + 32'd1;
      if (state_q == ROLLBACK) rollback_cnt_o <= rollback_cnt_o + 16'd1;
    end
  end
`endif

endmodule
